rope_tracker: RTL and testbench

Two-player rope-position tracker for the tug-of-war game, directly downstream of the per-player single-pulse input stage. It consumes one-cycle `pull` pulses from the left and right players and moves a single lit LED one step toward the puller. A pull past the end LED wins the round. After a fixed hold period the light re-centres automatically. Optional per-player win counters drive the score displays.

---
 rtl/tug_pkg.sv | 22 ++
 rtl/score_counter.sv | 20 ++
 rtl/rope_tracker.sv | 105 ++++++++++
 tb/tb_rope_tracker.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tug_pkg.sv
// Shared tug-of-war types: rope FSM states and the 2-bit winner encoding.
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    WIN_L = 2'd1,
    WIN_R = 2'd2
  } rope_state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_RIGHT = 2'b01;
  localparam logic [1:0] WIN_LEFT  = 2'b10;

  function automatic logic [1:0] win_code(input rope_state_t s);
    case (s)
      WIN_L:   win_code = WIN_LEFT;
      WIN_R:   win_code = WIN_RIGHT;
      default: win_code = WIN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/score_counter.sv
// Saturating win counter: count updates on the edge after inc, sticks at all-ones.
// No backpressure; every inc pulse is taken unless already saturated.
module score_counter #(
  parameter int SCORE_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  output logic [SCORE_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {SCORE_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rope_tracker.sv
// Tug-of-war rope position FSM; all outputs registered, latency 1 from pull to leds/winner/score.
// No backpressure: every pull in PLAY acts; pulls in win states are dropped. ROPE_SCORE_EN adds score counters.
module rope_tracker
  import tug_pkg::*;
#(
  parameter int NUM_LEDS    = 9,
  parameter int HOLD_CYCLES = 16,
  parameter int SCORE_W     = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pull_l,
  input  logic                pull_r,
  output logic [NUM_LEDS-1:0] leds,
  output logic [1:0]          winner,
  output logic                round_over,
  output logic [SCORE_W-1:0]  score_l,
  output logic [SCORE_W-1:0]  score_r
);

  localparam int PW = $clog2(NUM_LEDS);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [PW-1:0]       POS_MAX   = PW'(NUM_LEDS - 1);
  localparam logic [PW-1:0]       POS_C     = PW'((NUM_LEDS - 1) / 2);
  localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [NUM_LEDS-1:0] LED_ONE   = NUM_LEDS'(1);

  rope_state_t   state, state_nxt;
  logic [PW-1:0] pos, pos_nxt;
  logic [HW-1:0] hold, hold_nxt;

  logic pull_l_only, pull_r_only;
  assign pull_l_only = pull_l && !pull_r;
  assign pull_r_only = pull_r && !pull_l;

  // Pulling past an end LED becomes a win instead of wrapping the position.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    hold_nxt  = hold;
    case (state)
      PLAY: begin
        if (pull_l_only) begin
          if (pos < POS_MAX) pos_nxt = pos + 1'b1;
          else               state_nxt = WIN_L;
        end else if (pull_r_only) begin
          if (pos != '0) pos_nxt = pos - 1'b1;
          else           state_nxt = WIN_R;
        end
      end
      default: begin
        if (hold == HOLD_LAST) begin
          state_nxt = PLAY;
          pos_nxt   = POS_C;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PLAY;
      pos        <= POS_C;
      hold       <= '0;
      leds       <= LED_ONE << POS_C;
      winner     <= WIN_NONE;
      round_over <= 1'b0;
    end else begin
      state      <= state_nxt;
      pos        <= pos_nxt;
      hold       <= hold_nxt;
      leds       <= (state_nxt == PLAY) ? (LED_ONE << pos_nxt) : '0;
      winner     <= win_code(state_nxt);
      round_over <= (state_nxt != PLAY);
    end
  end

`ifdef ROPE_SCORE_EN
  logic win_l_evt, win_r_evt;
  assign win_l_evt = (state == PLAY) && pull_l_only && (pos == POS_MAX);
  assign win_r_evt = (state == PLAY) && pull_r_only && (pos == '0);

  score_counter #(.SCORE_W(SCORE_W)) u_score_l (
    .clk   (clk),
    .reset (reset),
    .inc   (win_l_evt),
    .count (score_l)
  );

  score_counter #(.SCORE_W(SCORE_W)) u_score_r (
    .clk   (clk),
    .reset (reset),
    .inc   (win_r_evt),
    .count (score_r)
  );
`else
  assign score_l = '0;
  assign score_r = '0;
`endif

endmodule

// File: tb/tb_rope_tracker.sv
// Bench for rope_tracker: directed scenarios plus random pulls against a behavioural game model.
module tb_rope_tracker;
  localparam int N    = 9;
  localparam int HOLD = 4;
  localparam int SW   = 3;
  localparam int C    = (N - 1) / 2;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          pull_l, pull_r;
  logic [N-1:0]  leds;
  logic [1:0]    winner;
  logic          round_over;
  logic [SW-1:0] score_l, score_r;

  rope_tracker #(.NUM_LEDS(N), .HOLD_CYCLES(HOLD), .SCORE_W(SW)) dut (
    .clk        (clk),
    .reset      (reset),
    .pull_l     (pull_l),
    .pull_r     (pull_r),
    .leds       (leds),
    .winner     (winner),
    .round_over (round_over),
    .score_l    (score_l),
    .score_r    (score_r)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Game model: position index, remaining win cycles, who won, score tallies.
  int  m_pos   = C;
  int  m_rem   = 0;
  bit  m_leftw = 1'b0;
  int  m_sl    = 0;
  int  m_sr    = 0;
  bit  chk_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = C; m_rem = 0; m_leftw = 1'b0; m_sl = 0; m_sr = 0;
  endtask

  function automatic int exp_leds();
    return (m_rem != 0) ? 0 : (1 << m_pos);
  endfunction

  function automatic int exp_winner();
    if (m_rem == 0) return 0;
    return m_leftw ? 2 : 1;
  endfunction

  function automatic int exp_score(input int s);
`ifdef ROPE_SCORE_EN
    return s;
`else
    return 0;
`endif
  endfunction

  task automatic model_edge(input bit pl, input bit pr);
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) m_pos = C;
    end else if (pl && !pr) begin
      if (m_pos == N - 1) begin
        m_rem = HOLD; m_leftw = 1'b1;
        if (m_sl < SMAX) m_sl++;
      end else m_pos++;
    end else if (pr && !pl) begin
      if (m_pos == 0) begin
        m_rem = HOLD; m_leftw = 1'b0;
        if (m_sr < SMAX) m_sr++;
      end else m_pos--;
    end
  endtask

  // One clock with the given pulls; returns #1 after the edge.
  task automatic step(input bit pl, input bit pr);
    pull_l = pl; pull_r = pr;
    @(posedge clk);
    if (!reset) model_edge(pl, pr);
    #1;
    pull_l = 1'b0; pull_r = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("leds", int'(leds), exp_leds());
      chk("winner", int'(winner), exp_winner());
      chk("round_over", int'(round_over), int'(m_rem != 0));
      chk("score_l", int'(score_l), exp_score(m_sl));
      chk("score_r", int'(score_r), exp_score(m_sr));
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pull_l = 1'b0; pull_r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk_en = 1'b1;

    chk("reset_leds", int'(leds), 'h010);
    chk("reset_winner", int'(winner), 0);
    chk("reset_round_over", int'(round_over), 0);
    chk("reset_score_l", int'(score_l), 0);

    repeat (4) step(1, 0);
    chk("left4_leds", int'(leds), 'h100);
    step(1, 0);
    chk("leftwin_winner", int'(winner), 2);
    chk("leftwin_round_over", int'(round_over), 1);
    chk("leftwin_leds", int'(leds), 0);
    chk("leftwin_score_l", int'(score_l), exp_score(1));
    repeat (HOLD) step(0, 0);
    chk("recentre_leds", int'(leds), 'h010);

    repeat (3) step(1, 1);
    chk("cancel_leds", int'(leds), 'h010);

    repeat (5) step(0, 1);
    chk("rightwin_winner", int'(winner), 1);
    repeat (HOLD - 1) begin
      step(1, 0);
      chk("rightwin_ignore_round_over", int'(round_over), 1);
    end
    step(1, 0);
    chk("rightwin_exit_leds", int'(leds), 'h010);
    chk("rightwin_exit_winner", int'(winner), 0);
    chk("rightwin_score_r", int'(score_r), exp_score(1));

    // Asynchronous reset in the middle of a hold period.
    repeat (5) step(1, 0);
    step(0, 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_leds", int'(leds), 'h010);
    chk("async_winner", int'(winner), 0);
    chk("async_round_over", int'(round_over), 0);
    chk("async_score_l", int'(score_l), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Saturation of the left score.
    do_reset();
    for (int w = 1; w <= 8; w++) begin
      repeat (5) step(1, 0);
      if (w >= 7) chk("sat_score_l", int'(score_l), exp_score(7));
      repeat (HOLD) step(0, 0);
    end

    do_reset();
    for (int seg = 0; seg < 30; seg++) begin
      for (int i = 0; i < 100; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (seg % 2 == 0) step(r < 5, (r >= 4) && (r < 7));
        else              step(r >= 7 || r == 0, (r >= 1) && (r < 6));
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
